// File: rtl/biu_constants_pkg.sv
// Shared BIU transfer attribute types and the burst-type to beat-count helper.
package biu_constants_pkg;

    typedef enum logic [2:0] {
        BYTE  = 3'd0,
        HWORD = 3'd1,
        WORD  = 3'd2,
        DWORD = 3'd3,
        QWORD = 3'd4,
        OWORD = 3'd5
    } biu_size_t;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } biu_type_t;

    typedef logic [2:0] biu_prot_t;

    localparam int BEAT_W = 4;

    // Burst length minus one; undefined-length INCR is treated as a single beat.
    function automatic logic [BEAT_W-1:0] biu_type2cnt(input biu_type_t t);
        case (t)
            WRAP4,  INCR4:  return 4'd3;
            WRAP8,  INCR8:  return 4'd7;
            WRAP16, INCR16: return 4'd15;
            default:        return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/biu_arb_queue.sv
// Synchronous FIFO holding the owners of accepted requests awaiting data.
// full_o is registered; pushes while full and pops while empty are ignored.
module biu_arb_queue #(
    parameter int DEPTH = 2,
    parameter int DW    = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o,
    output logic          empty_o,
    output logic          full_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DW-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_full;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_push    = push_i & ~r_full;
    assign w_pop     = pop_i & (r_cnt != '0);
    assign w_cnt_nxt = r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);

    // Entry storage; data only, so no reset.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= din_i;
    end

    // Pointers, occupancy and the registered full flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_cnt  <= w_cnt_nxt;
            r_full <= (w_cnt_nxt == CNT_W'(DEPTH));
        end
    end

    assign dout_o  = r_mem[r_rd_ptr];
    assign empty_o = (r_cnt == '0);
    assign full_o  = r_full;

endmodule

// File: rtl/biu_rr_arbiter.sv
// Round-robin arbiter sharing one BIU between PORTS requesters. The address
// phase rotates priority per accepted request; a port-ID queue routes the
// data phase back to the owner so address and data phases can overlap.
// Optional macro BIU_ARB_LOCK_EN: a locked accept keeps arbitration on that
// port for as long as it holds biu_lock_i.
module biu_rr_arbiter
    import biu_constants_pkg::*;
#(
    parameter int ADDR_SIZE   = 32,
    parameter int DATA_SIZE   = 32,
    parameter int PORTS       = 2,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [PORTS-1:0]     biu_req_i,
    output logic [PORTS-1:0]     biu_req_ack_o,
    output logic [PORTS-1:0]     biu_d_ack_o,
    input  logic [ADDR_SIZE-1:0] biu_adri_i [PORTS],
    output logic [ADDR_SIZE-1:0] biu_adro_o [PORTS],
    input  biu_size_t            biu_size_i [PORTS],
    input  biu_type_t            biu_type_i [PORTS],
    input  biu_prot_t            biu_prot_i [PORTS],
    input  logic [PORTS-1:0]     biu_lock_i,
    input  logic [PORTS-1:0]     biu_we_i,
    input  logic [DATA_SIZE-1:0] biu_d_i [PORTS],
    output logic [DATA_SIZE-1:0] biu_q_o [PORTS],
    output logic [PORTS-1:0]     biu_ack_o,
    output logic [PORTS-1:0]     biu_err_o,
    output logic                 biu_req_o,
    input  logic                 biu_req_ack_i,
    output logic [ADDR_SIZE-1:0] biu_adri_o,
    output biu_size_t            biu_size_o,
    output biu_type_t            biu_type_o,
    output logic                 biu_lock_o,
    output biu_prot_t            biu_prot_o,
    output logic                 biu_we_o,
    output logic [DATA_SIZE-1:0] biu_d_o,
    input  logic                 biu_d_ack_i,
    input  logic                 biu_ack_i,
    input  logic                 biu_err_i,
    input  logic [ADDR_SIZE-1:0] biu_adro_i,
    input  logic [DATA_SIZE-1:0] biu_q_i
);

    localparam int PORT_W = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef struct packed {
        logic [PORT_W-1:0] port;
        logic [BEAT_W-1:0] beats;
    } q_entry_t;

    typedef enum logic {ARB, HOLD} arb_state_t;

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [PORT_W-1:0] r_last;
    logic [PORT_W-1:0] r_held;
    logic [PORT_W-1:0] w_held_nxt;
    logic [PORT_W-1:0] w_rr_grant;
    logic [PORT_W-1:0] w_grant;
    logic              w_req_any;
    logic              w_accept;
    logic              w_lock_act;
    logic [PORT_W-1:0] w_lock_port;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    q_entry_t          w_push_entry;
    q_entry_t          w_head;
    logic [BEAT_W-1:0] r_beat;

    // First requesting port after the last grant, searching cyclically.
    always_comb begin
        logic              v_found;
        logic [PORT_W-1:0] v_idx;
        v_found    = 1'b0;
        v_idx      = '0;
        w_rr_grant = r_last;
        for (int i = 1; i <= PORTS; i++) begin
            v_idx = PORT_W'((int'(r_last) + i) % PORTS);
            if (!v_found && biu_req_i[v_idx]) begin
                w_rr_grant = v_idx;
                v_found    = 1'b1;
            end
        end
    end

`ifdef BIU_ARB_LOCK_EN
    logic              r_locked;
    logic [PORT_W-1:0] r_lock_port;

    assign w_lock_act  = r_locked & biu_lock_i[r_lock_port];
    assign w_lock_port = r_lock_port;

    // Lock is taken on a locked accept and released once the owner drops biu_lock_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_locked    <= 1'b0;
            r_lock_port <= '0;
        end else if (w_accept) begin
            r_locked    <= biu_lock_i[w_grant];
            r_lock_port <= w_grant;
        end else if (!w_lock_act) begin
            r_locked    <= 1'b0;
        end
    end
`else
    assign w_lock_act  = 1'b0;
    assign w_lock_port = '0;
`endif

    // FSM next state, grant selection and request qualification.
    always_comb begin
        w_state_nxt = r_state;
        w_held_nxt  = r_held;
        w_grant     = w_rr_grant;
        w_req_any   = |biu_req_i;
        case (r_state)
            ARB: begin
                if (w_lock_act) begin
                    w_grant   = w_lock_port;
                    w_req_any = biu_req_i[w_lock_port];
                end
                if (w_req_any && !w_full && !biu_req_ack_i) begin
                    w_state_nxt = HOLD;
                    w_held_nxt  = w_grant;
                end
            end
            HOLD: begin
                w_grant   = r_held;
                w_req_any = biu_req_i[r_held];
                if (!w_req_any || (!w_full && biu_req_ack_i)) w_state_nxt = ARB;
            end
            default: w_state_nxt = ARB;
        endcase
    end

    // FSM state and held-port register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ARB;
            r_held  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_held  <= w_held_nxt;
        end
    end

    assign biu_req_o  = w_req_any & ~w_full;
    assign w_accept   = biu_req_o & biu_req_ack_i;
    assign biu_adri_o = biu_adri_i[w_grant];
    assign biu_size_o = biu_size_i[w_grant];
    assign biu_type_o = biu_type_i[w_grant];
    assign biu_prot_o = biu_prot_i[w_grant];
    assign biu_lock_o = biu_lock_i[w_grant];
    assign biu_we_o   = biu_we_i[w_grant];

    // Priority rotates from the port that was just accepted; port 0 wins first after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       r_last <= PORT_W'(PORTS - 1);
        else if (w_accept) r_last <= w_grant;
    end

    // Zero-latency request acknowledge to the granted port only.
    always_comb begin
        biu_req_ack_o = '0;
        if (w_accept) biu_req_ack_o[w_grant] = 1'b1;
    end

    assign w_push_entry.port  = w_grant;
    assign w_push_entry.beats = biu_type2cnt(biu_type_i[w_grant]);

    biu_arb_queue #(
        .DEPTH (QUEUE_DEPTH),
        .DW    ($bits(q_entry_t))
    ) u_queue (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_accept),
        .pop_i   (w_pop),
        .din_i   (w_push_entry),
        .dout_o  (w_head),
        .empty_o (w_empty),
        .full_o  (w_full)
    );

    // An error aborts the rest of the burst, so it pops immediately.
    assign w_pop   = ~w_empty & (biu_err_i | (biu_ack_i & (r_beat == w_head.beats)));
    assign biu_d_o = w_empty ? biu_d_i[w_grant] : biu_d_i[w_head.port];

    // Data-phase handshakes go to the head-of-queue owner; dropped when nothing is outstanding.
    always_comb begin
        biu_ack_o   = '0;
        biu_err_o   = '0;
        biu_d_ack_o = '0;
        if (!w_empty) begin
            biu_ack_o[w_head.port]   = biu_ack_i;
            biu_err_o[w_head.port]   = biu_err_i;
            biu_d_ack_o[w_head.port] = biu_d_ack_i;
        end
    end

    // Response address and read data are broadcast; the per-port ack qualifies them.
    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            biu_adro_o[p] = biu_adro_i;
            biu_q_o[p]    = biu_q_i;
        end
    end

    // Beat counter for the head burst.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                    r_beat <= '0;
        else if (w_pop)                 r_beat <= '0;
        else if (!w_empty && biu_ack_i) r_beat <= r_beat + 1'b1;
    end

endmodule

// File: tb/tb_biu_rr_arbiter.sv
// Scoreboard bench for biu_rr_arbiter (PORTS=2, QUEUE_DEPTH=2).
module tb_biu_rr_arbiter;
    import biu_constants_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_i;
    logic [1:0]  req_ack_o;
    logic [1:0]  d_ack_o;
    logic [31:0] adri_i [2];
    logic [31:0] adro_o [2];
    biu_size_t   size_i [2];
    biu_type_t   type_i [2];
    biu_prot_t   prot_i [2];
    logic [1:0]  lock_i;
    logic [1:0]  we_i;
    logic [31:0] d_i [2];
    logic [31:0] q_o [2];
    logic [1:0]  ack_o;
    logic [1:0]  err_o;
    logic        biu_req_o;
    logic        biu_req_ack_i;
    logic [31:0] biu_adri_o;
    biu_size_t   biu_size_o;
    biu_type_t   biu_type_o;
    logic        biu_lock_o;
    biu_prot_t   biu_prot_o;
    logic        biu_we_o;
    logic [31:0] biu_d_o;
    logic        biu_d_ack_i;
    logic        biu_ack_i;
    logic        biu_err_i;
    logic [31:0] biu_adro_i;
    logic [31:0] biu_q_i;

    int n_cmp = 0;
    int n_bad = 0;
    logic [1:0] q_gnt [$];
    logic [3:0] q_dat [$];
    logic [1:0] g_exp;
    logic [3:0] d_exp;

    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h2000_0000;
    localparam logic [31:0] D0 = 32'hDDDD_0000;
    localparam logic [31:0] D1 = 32'hDDDD_1111;

    biu_rr_arbiter #(
        .ADDR_SIZE(32), .DATA_SIZE(32), .PORTS(2), .QUEUE_DEPTH(2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .biu_req_i(req_i), .biu_req_ack_o(req_ack_o), .biu_d_ack_o(d_ack_o),
        .biu_adri_i(adri_i), .biu_adro_o(adro_o),
        .biu_size_i(size_i), .biu_type_i(type_i), .biu_prot_i(prot_i),
        .biu_lock_i(lock_i), .biu_we_i(we_i),
        .biu_d_i(d_i), .biu_q_o(q_o),
        .biu_ack_o(ack_o), .biu_err_o(err_o),
        .biu_req_o(biu_req_o), .biu_req_ack_i(biu_req_ack_i),
        .biu_adri_o(biu_adri_o), .biu_size_o(biu_size_o), .biu_type_o(biu_type_o),
        .biu_lock_o(biu_lock_o), .biu_prot_o(biu_prot_o), .biu_we_o(biu_we_o),
        .biu_d_o(biu_d_o),
        .biu_d_ack_i(biu_d_ack_i), .biu_ack_i(biu_ack_i), .biu_err_i(biu_err_i),
        .biu_adro_i(biu_adro_i), .biu_q_i(biu_q_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required finish before 100000");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drv(input logic [1:0] rq, input logic rqa, input logic ak, input logic er);
        req_i         = rq;
        biu_req_ack_i = rqa;
        biu_ack_i     = ak;
        biu_err_i     = er;
    endtask

    // Monitor: pops expected grants / data handshakes whenever the DUT presents one.
    always @(negedge clk) begin
        if (rst_n) begin
            if (|req_ack_o) begin
                if (q_gnt.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL grant_unexpected: got req_ack_o=%b, expected none", req_ack_o);
                end else begin
                    g_exp = q_gnt.pop_front();
                    chk("grant", {62'd0, req_ack_o}, {62'd0, g_exp});
                end
            end
            if (|ack_o || |err_o) begin
                if (q_dat.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL data_unexpected: got err_o=%b ack_o=%b, expected none", err_o, ack_o);
                end else begin
                    d_exp = q_dat.pop_front();
                    chk("data_route", {60'd0, err_o, ack_o}, {60'd0, d_exp});
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        drv(2'b00, 1'b0, 1'b0, 1'b0);
        lock_i = 2'b00; we_i = 2'b01; biu_d_ack_i = 1'b0;
        biu_adro_i = 32'hA5A5_0001; biu_q_i = 32'h5A5A_0002;
        for (int p = 0; p < 2; p++) begin
            size_i[p] = WORD; type_i[p] = SINGLE; prot_i[p] = '0;
        end
        adri_i[0] = A0; adri_i[1] = A1; d_i[0] = D0; d_i[1] = D1;
        repeat (2) nxt();
        rst_n = 1'b1;

        // Reset state: empty queue drops every data handshake
        drv(2'b00, 1'b1, 1'b1, 1'b1);
        biu_d_ack_i = 1'b1;
        mid();
        chk("rst_req_o", biu_req_o, 0);
        chk("rst_req_ack_o", req_ack_o, 0);
        chk("rst_ack_o", ack_o, 0);
        chk("rst_err_o", err_o, 0);
        chk("rst_d_ack_o", d_ack_o, 0);
        chk("bcast_q", q_o[1], 32'h5A5A_0002);
        chk("bcast_adro", adro_o[0], 32'hA5A5_0001);
        nxt();
        biu_d_ack_i = 1'b0;

        // Test 1: both request, BIU accepts every cycle -> 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            drv(2'b11, 1'b1, 1'b1, 1'b0);
            q_gnt.push_back((k % 2 == 0) ? 2'b01 : 2'b10);
            if (k > 0) q_dat.push_back((k % 2 == 1) ? 4'b0001 : 4'b0010);
            nxt();
        end
        drv(2'b00, 1'b0, 1'b1, 1'b0);
        q_dat.push_back(4'b0010);
        nxt();

        // Test 2: P1 INCR4, four acks routed to P1, then queue empty
        type_i[1] = INCR4;
        drv(2'b10, 1'b1, 1'b0, 1'b0);
        q_gnt.push_back(2'b10);
        nxt();
        type_i[1] = SINGLE;
        for (int b = 0; b < 4; b++) begin
            drv(2'b00, 1'b0, 1'b1, 1'b0);
            biu_d_ack_i = (b == 0);
            q_dat.push_back(4'b0010);
            mid();
            if (b == 0) begin
                chk("d_ack_route", d_ack_o, 2'b10);
                chk("wdata_head", biu_d_o, D1);
            end
            nxt();
        end
        biu_d_ack_i = 1'b0;
        drv(2'b00, 1'b0, 1'b1, 1'b0);
        nxt();

        // Test 3: two SINGLE accepts fill the queue; no accept until a pop has registered
        drv(2'b01, 1'b1, 1'b0, 1'b0);
        q_gnt.push_back(2'b01);
        nxt();
        q_gnt.push_back(2'b01);
        nxt();
        for (int c = 0; c < 2; c++) begin
            mid();
            chk("full_req_o", biu_req_o, 0);
            nxt();
        end
        drv(2'b01, 1'b1, 1'b1, 1'b0);
        q_dat.push_back(4'b0001);
        mid();
        chk("full_pop_req_o", biu_req_o, 0);
        nxt();
        q_gnt.push_back(2'b01);
        q_dat.push_back(4'b0001);
        mid();
        chk("after_pop_req_o", biu_req_o, 1);
        nxt();
        drv(2'b00, 1'b0, 1'b1, 1'b0);
        q_dat.push_back(4'b0001);
        nxt();

        // Test 4: error on beat 2 of P0 WRAP8 aborts it; next ack goes to P1
        type_i[0] = WRAP8;
        drv(2'b01, 1'b1, 1'b0, 1'b0);
        q_gnt.push_back(2'b01);
        nxt();
        type_i[0] = SINGLE;
        drv(2'b10, 1'b1, 1'b0, 1'b0);
        q_gnt.push_back(2'b10);
        nxt();
        drv(2'b00, 1'b0, 1'b1, 1'b0);
        q_dat.push_back(4'b0001);
        nxt();
        drv(2'b00, 1'b0, 1'b0, 1'b1);
        q_dat.push_back(4'b0100);
        nxt();
        drv(2'b00, 1'b0, 1'b1, 1'b0);
        q_dat.push_back(4'b0010);
        nxt();
        nxt();

        // Test 5: P1 held 5 cycles without accept while P0 also requests
        drv(2'b10, 1'b0, 1'b0, 1'b0);
        mid();
        chk("hold_req_o", biu_req_o, 1);
        chk("hold_adr_0", biu_adri_o, A1);
        nxt();
        for (int c = 0; c < 4; c++) begin
            drv(2'b11, 1'b0, 1'b0, 1'b0);
            mid();
            chk("hold_adr", biu_adri_o, A1);
            nxt();
        end
        drv(2'b11, 1'b1, 1'b0, 1'b0);
        q_gnt.push_back(2'b10);
        mid();
        chk("hold_accept_adr", biu_adri_o, A1);
        nxt();
        drv(2'b01, 1'b1, 1'b0, 1'b0);
        q_gnt.push_back(2'b01);
        mid();
        chk("after_hold_adr", biu_adri_o, A0);
        nxt();
        drv(2'b00, 1'b0, 1'b1, 1'b0);
        q_dat.push_back(4'b0010);
        nxt();
        q_dat.push_back(4'b0001);
        nxt();

        // Reset in the middle of a P1 INCR4 burst clears the queue
        type_i[1] = INCR4;
        drv(2'b10, 1'b1, 1'b0, 1'b0);
        q_gnt.push_back(2'b10);
        nxt();
        type_i[1] = SINGLE;
        drv(2'b00, 1'b0, 1'b1, 1'b0);
        q_dat.push_back(4'b0010);
        nxt();
        drv(2'b00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        nxt();
        nxt();
        rst_n = 1'b1;
        drv(2'b00, 1'b0, 1'b1, 1'b0);
        mid();
        chk("rst_mid_ack_o", ack_o, 0);
        nxt();

        // Test 6: P0 holds lock for 3 requests while P1 also requests
        lock_i = 2'b01;
        for (int k = 0; k < 3; k++) begin
            drv(2'b11, 1'b1, 1'b1, 1'b0);
`ifdef BIU_ARB_LOCK_EN
            q_gnt.push_back(2'b01);
            if (k > 0) q_dat.push_back(4'b0001);
`else
            q_gnt.push_back((k == 1) ? 2'b10 : 2'b01);
            if (k > 0) q_dat.push_back((k == 2) ? 4'b0010 : 4'b0001);
`endif
            mid();
            chk("lock_pass", biu_lock_o, (k == 1) ? 1'b0 : 1'b1);
            nxt();
        end
        lock_i = 2'b00;
        drv(2'b10, 1'b1, 1'b1, 1'b0);
        q_gnt.push_back(2'b10);
        q_dat.push_back(4'b0001);
        nxt();
        drv(2'b00, 1'b0, 1'b1, 1'b0);
        q_dat.push_back(4'b0010);
        nxt();

        drv(2'b00, 1'b0, 1'b0, 1'b0);
        repeat (3) nxt();
        chk("sb_grant_left", q_gnt.size(), 0);
        chk("sb_data_left", q_dat.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
